// File: rtl/snn_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snn_link_pkg
// Description : Shared constants and state type for the NEXT/FINISH image
//               link between the chunk sender and the SNN image loader.
//               Used by both the transmit and the receive side.
// Revision    : 1.0 - initial release
// ============================================================================
package snn_link_pkg;

    localparam int WORD_W           = 32;
    localparam int CHUNK_WORDS      = 14;
    localparam int TOTAL_WORDS      = 25;
    localparam int LAST_CHUNK_WORDS = TOTAL_WORDS - CHUNK_WORDS;   // 11
    localparam int FINISH_OFFSET    = CHUNK_WORDS * WORD_W;         // 448
    localparam int IMAGE_BITS       = TOTAL_WORDS * WORD_W;         // 800

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_PULSE = 3'd2,
        ST_GAP   = 3'd3,
        ST_TAIL  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/image_chunk_sender_chunk_buffer.sv
`default_nettype none
// ============================================================================
// Module      : chunk_buffer
// Description : WORDS x WIDTH register file holding one chunk. Single write
//               port addressed by index, synchronous clear of all slots, and
//               a flat parallel read-out (slot k at bits [k*WIDTH +: WIDTH]).
// Ports       : clk, rst (async, active-high), clear, wr_en, wr_idx, wr_data,
//               data (flat parallel output)
// Revision    : 1.0 - initial release
// ============================================================================
module chunk_buffer
    import snn_link_pkg::*;
#(
    parameter int WORDS = CHUNK_WORDS,
    parameter int WIDTH = WORD_W,
    parameter int IDX_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WORDS*WIDTH-1:0] data
);

    logic [WIDTH-1:0] r_mem [WORDS];

    // Clear has priority over a write; the controller never issues both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) r_mem[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < WORDS; i++) r_mem[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < WORDS; i++) begin
                if (wr_idx == IDX_W'(i)) r_mem[i] <= wr_data;
            end
        end
    end

    for (genvar gi = 0; gi < WORDS; gi++) begin : g_flat
        assign data[gi*WIDTH +: WIDTH] = r_mem[gi];
    end

endmodule
`default_nettype wire

// File: rtl/image_chunk_sender.sv
`default_nettype none
// ============================================================================
// Module      : image_chunk_sender
// Description : Collects a 25-word image from a valid/ready stream, presents
//               it as a 14-word chunk and an 11-word chunk on a parallel bus,
//               strobing NEXT per chunk and FINISH on the last one.
// Ports       : clk, rst (async, active-high)
//               start                  - begin one image (honoured in IDLE)
//               in_word/in_valid/in_ready - word stream, word 0 first
//               chunk_data             - current chunk, slot k at [32k+31:32k]
//               next, finish           - link strobes to the loader
//               busy                   - high outside IDLE
//               done                   - one-cycle end-of-image pulse
// Revision    : 1.0 - initial release
// ============================================================================
module image_chunk_sender
    import snn_link_pkg::*;
#(
    parameter int NEXT_HOLD   = 2,
    parameter int GAP         = 2,
    parameter int FINISH_TAIL = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [WORD_W-1:0]             in_word,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [CHUNK_WORDS*WORD_W-1:0] chunk_data,
    output logic                          next,
    output logic                          finish,
    output logic                          busy,
    output logic                          done
);

    localparam int               TMR_W       = 8;
    localparam logic [TMR_W-1:0] c_hold_init = TMR_W'(NEXT_HOLD - 1);
    localparam logic [TMR_W-1:0] c_gap_init  = TMR_W'(GAP - 1);
    localparam logic [TMR_W-1:0] c_tail_init = TMR_W'(FINISH_TAIL - 1);
    localparam logic [3:0]       c_chunk     = 4'(CHUNK_WORDS);
    localparam logic [4:0]       c_total     = 5'(TOTAL_WORDS);

    state_t           r_state;
    logic [3:0]       r_word_idx;
    logic [4:0]       r_total;
    logic [TMR_W-1:0] r_timer;
    logic             r_in_ready;
    logic             r_next;
    logic             r_finish;
    logic             r_done;

    logic       w_accept;
    logic       w_clear;
    logic [3:0] w_idx_inc;
    logic [4:0] w_total_inc;
    logic       w_chunk_end;

    assign w_accept    = (r_state == ST_FILL) && in_valid && r_in_ready;
    assign w_idx_inc   = r_word_idx + 4'd1;
    assign w_total_inc = r_total + 5'd1;
    // A chunk closes on a full buffer or on the last word of the image.
    assign w_chunk_end = (w_idx_inc == c_chunk) || (w_total_inc == c_total);
    // The buffer is wiped when an image starts and when a gap ends, so the
    // short last chunk reads zero in its unused slots.
    assign w_clear     = ((r_state == ST_IDLE) && start) ||
                         ((r_state == ST_GAP) && (r_timer == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_word_idx <= '0;
            r_total    <= '0;
            r_timer    <= '0;
            r_in_ready <= 1'b0;
            r_next     <= 1'b0;
            r_finish   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_FILL;
                        r_word_idx <= '0;
                        r_total    <= '0;
                        r_in_ready <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (w_accept) begin
                        r_word_idx <= (r_word_idx == c_chunk) ? r_word_idx : w_idx_inc;
                        r_total    <= (r_total == c_total) ? r_total : w_total_inc;
                        if (w_chunk_end) begin
                            r_state    <= ST_PULSE;
                            r_in_ready <= 1'b0;
                            r_next     <= 1'b1;
                            r_finish   <= (w_total_inc == c_total);
                            r_timer    <= c_hold_init;
                        end
                    end
                end
                ST_PULSE: begin
                    if (r_timer == '0) begin
                        r_next <= 1'b0;
                        if (r_total != c_total) begin
                            r_state <= ST_GAP;
                            r_timer <= c_gap_init;
                        end else if (FINISH_TAIL == 0) begin
                            r_state  <= ST_DONE;
                            r_finish <= 1'b0;
                            r_done   <= 1'b1;
                        end else begin
                            r_state <= ST_TAIL;
                            r_timer <= c_tail_init;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_timer == '0) begin
                        r_state    <= ST_FILL;
                        r_word_idx <= '0;
                        r_in_ready <= 1'b1;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                ST_TAIL: begin
                    if (r_timer == '0) begin
                        r_state  <= ST_DONE;
                        r_finish <= 1'b0;
                        r_done   <= 1'b1;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b0;
                    r_next     <= 1'b0;
                    r_finish   <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    chunk_buffer #(
        .WORDS (CHUNK_WORDS),
        .WIDTH (WORD_W),
        .IDX_W (4)
    ) u_chunk_buffer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_clear),
        .wr_en   (w_accept),
        .wr_idx  (r_word_idx),
        .wr_data (in_word),
        .data    (chunk_data)
    );

    assign in_ready = r_in_ready;
    assign next     = r_next;
    assign finish   = r_finish;
    assign done     = r_done;
    assign busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire
